// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed configurable UART transmitter.
package uart_pkg;

    localparam int unsigned MIN_BAUD = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a write is accepted when full only if a read happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           rd_en,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_ok_c, rd_ok_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ok_c  = rd_en && !empty_q;
        wr_ok_c  = wr_en && (!full_q || rd_ok_c);
        wr_ptr_d = wr_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_c && !rd_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok_c && !wr_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a TX FIFO; divisor, parity and stop bits are latched per frame at pop.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BAUD_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [BAUD_W-1:0]                  baud_cnt,
    input  logic [1:0]                         parity_mode,
    input  logic                               two_stop,
    input  logic                               wr_en,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               overflow,
    output logic                               TX,
    output logic                               tx_busy,
    output logic                               tx_done
);

    localparam int unsigned IDX_W = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] div_q, div_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              two_stop_q, two_stop_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              pop_c, bit_end_c;
    logic [BAUD_W-1:0] eff_baud_c;
    logic [DATA_W-1:0] head_c;
    parity_e           par_mode_c;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_c),
        .rd_data (head_c),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;
        done_d     = 1'b0;
        pop_c      = 1'b0;
        eff_baud_c = (baud_cnt < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : baud_cnt;
        par_mode_c = decode_parity(parity_mode);
        bit_end_c  = (baud_q == BAUD_W'(1));
        busy_d     = (state_q != IDLE);
        ovf_d      = wr_en && full && !pop_c;

        // Bit timer: reload at each bit boundary, otherwise count down.
        if (state_q != IDLE) begin
            baud_d = bit_end_c ? div_q : baud_q - BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop_c = 1'b1;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end_c) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IDX_W'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop2_d = 1'b0;
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = par_bit_q;
                if (bit_end_c) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end_c) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (!empty) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ovf_d = wr_en && full && !pop_c;

        // Pop: capture the head word and freeze this frame's configuration.
        if (pop_c) begin
            state_d    = START;
            div_d      = eff_baud_c;
            baud_d     = eff_baud_c;
            shift_d    = head_c;
            par_en_d   = (par_mode_c != PAR_NONE);
            par_bit_d  = (^head_c) ^ (par_mode_c == PAR_ODD);
            two_stop_d = two_stop;
            stop2_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= BAUD_W'(MIN_BAUD);
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TX       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
- Next-generation UART transmitter: parametrised data width, selectable parity, 1 or 2 stop bits, runtime-programmable baud divisor, and an internal transmit FIFO.
- Sits where the single-byte configurable-baud transmitter sits: the host pushes words without waiting for tx_done, and frames go out back-to-back.
- Drives the same serial line the UART protocol trigger block samples, so its output format must stay LSB-first 8N1-compatible when configured 8/none/1.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- BAUD_W, 16, width of the baud divisor (clock cycles per bit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_cnt  in  BAUD_W  cycles per bit; values 0 and 1 are treated as 2.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- wr_en  in  1  push wr_data into the FIFO this cycle.
- wr_data  in  DATA_W  word to transmit.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when wr_en is dropped because the FIFO is full.
- TX  out  1  serial line, registered, idles high.
- tx_busy  out  1  high from the start bit through the final stop bit.
- tx_done  out  1  one-cycle pulse on the final cycle of each frame's last stop bit.

Behaviour:
- Reset (async assert, sync release):
  - TX=1, tx_busy=0, tx_done=0, overflow=0.
  - FIFO pointers cleared: count=0, empty=1, full=0.
  - FSM returns to IDLE.
- Reset asserted mid-frame: TX returns high immediately; the partial frame and all FIFO contents are discarded.
- FIFO write and read:
  - A write is accepted if not full, or if a pop occurs in the same cycle. A write to a full FIFO with no pop is dropped and pulses overflow on the next cycle.
  - Pop happens only on the IDLE→START transition or the STOP→START transition, and takes the head word into the shift register.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame configuration: baud_cnt, parity_mode and two_stop are latched at pop. Changing them mid-frame affects only later frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX=1. If the FIFO is not empty, pop and go to START.
  - START: TX=0 for one bit period.
  - DATA: DATA_W bits, LSB first, one bit period each.
  - PARITY: entered only if parity is enabled. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: TX=1 for 1 or 2 bit periods. On the final cycle, pulse tx_done. Then go to START if the FIFO is not empty (pop in the same cycle, no idle gap), otherwise go to IDLE.
- Bit timing: the baud counter loads the latched divisor at each bit boundary and counts down; a bit ends when it reaches 1. Each bit lasts exactly max(baud_cnt,2) cycles.
- Frame length: (1 + DATA_W + P + S) × bit period cycles, where P is 0 or 1 and S is 1 or 2.
- Latency: wr_en at edge N into an empty FIFO with the FSM in IDLE: count=1 after N, and TX=0 after edge N+2.
- tx_busy: high while the FSM is not in IDLE; stays high across back-to-back frames.
- Width rules: the bit index counter is $clog2(DATA_W+1) bits; the baud counter is BAUD_W bits with no overflow.

Decomposition:
- Package uart_pkg:
  - parity_e enum: PAR_NONE, PAR_EVEN, PAR_ODD.
  - tx_state_e enum for the FSM states.
  - Constant MIN_BAUD=2.
- Sub-module uart_sync_fifo: parametrised DATA_W/DEPTH single-clock FIFO with full, empty and count outputs. The transmitter FSM, baud counter and shifter stay in the top level.

Test Plan:
- Reset, then baud_cnt=16, 8/none/1, write 8'hA5 → TX low 2 cycles after the write edge. Each bit lasts 16 cycles, LSB first: 1,0,1,0,0,1,0,1. Stop high. tx_done pulses at cycle 160 of the frame.
- Parity_mode=01 then 10, data 8'hC3 → parity bit 0 for even, 1 for odd. Frame is 11 bits. A loopback through the UART protocol trigger block (configured 8N1) is not required in this case.
- two_stop=1, baud_cnt=4, write 3 words in consecutive cycles → frames back-to-back with no idle cycles. Three tx_done pulses 44 cycles apart. tx_busy stays high throughout. count goes 3→2→1→0.
- Fill 8 words while the first frame is transmitting, then write a 10th word with no pop → full=1, overflow pulses once, and the dropped word never appears on TX. A write coinciding with a pop while full is accepted.
- baud_cnt=0 and 1 → bit period is 2 cycles. Changing baud_cnt from 16 to 8 mid-frame → the current frame stays at 16 cycles per bit, the next frame uses 8.
- rst_n asserted during DATA bit 3 → TX=1 asynchronously, count=0. After release, no further TX activity until a new write.
